// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its word array.
// FSM encoding, default latency/depth, and the illegal-request rule.
package mem_pkg;

   localparam int DATA_W      = 16;
   localparam int CNT_W       = 4;
   localparam int DEF_LATENCY = 4;
   localparam int DEF_AW      = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Both strobes at once or an odd byte address cannot be serviced.
   function automatic logic is_illegal(input logic rd, input logic wr, input logic addr_lsb);
      return (rd & wr) | addr_lsb;
   endfunction

endpackage

// File: rtl/mem_array_sync.sv
// 2^AW x DW word store: synchronous write, combinational read.
// No reset; contents survive responder reset.
module mem_array_sync
   import mem_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DATA_W
) (
   input  logic          clk,
   input  logic          wr_vld,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_dat,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_dat
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_vld) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: Done pulses LATENCY cycles after accept.
// Stall is high while busy; requests seen during BUSY/RESP are dropped, not queued.
module mem_responder
   import mem_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY,
   parameter int AW      = DEF_AW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        err
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [AW:0]        cap_addr;
   logic [DATA_W-1:0]  cap_dat;
   logic               cap_rd, cap_wr;
   logic               accept, finish, illegal;
   logic               done_nxt, stall_nxt, err_nxt;
   logic [DATA_W-1:0]  dout_nxt;
   logic [DATA_W-1:0]  rd_dat;
   logic               wr_vld;

   // Upper address bits fold away: the array is addressed modulo its byte size.
   logic unused_addr_hi;
   assign unused_addr_hi = ^Addr[15:AW+1];

   assign illegal = is_illegal(cap_rd, cap_wr, cap_addr[0]);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Rd | Wr) begin
               accept    = 1'b1;
               cnt_nxt   = CNT_W'(LATENCY - 2);
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt == '0) begin
               finish    = 1'b1;
               state_nxt = ST_RESP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      done_nxt  = finish;
      stall_nxt = (state_nxt == ST_BUSY);
      err_nxt   = finish & illegal;
      dout_nxt  = DataOut;
      if (finish & illegal) begin
         dout_nxt = '0;
      end else if (finish & cap_rd) begin
         dout_nxt = rd_dat;
      end
   end

   // Gated by rst so a reset landing on the commit edge drops the write.
   assign wr_vld = finish & ~illegal & cap_wr & rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         Done     <= 1'b0;
         Stall    <= 1'b0;
         err      <= 1'b0;
         DataOut  <= '0;
         cap_addr <= '0;
         cap_dat  <= '0;
         cap_rd   <= 1'b0;
         cap_wr   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         Done    <= done_nxt;
         Stall   <= stall_nxt;
         err     <= err_nxt;
         DataOut <= dout_nxt;
         if (accept) begin
            cap_addr <= Addr[AW:0];
            cap_dat  <= DataIn;
            cap_rd   <= Rd;
            cap_wr   <= Wr;
         end
      end
   end

   mem_array_sync #(
      .AW (AW),
      .DW (DATA_W)
   ) u_array (
      .clk     (clk),
      .wr_vld  (wr_vld),
      .wr_addr (cap_addr[AW:1]),
      .wr_dat  (cap_dat),
      .rd_addr (cap_addr[AW:1]),
      .rd_dat  (rd_dat)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a transaction-level reference model.
// Directed cases pin the model with hand-computed literal results.
module tb_mem_responder;

   localparam int L = 4;

   logic        clk;
   logic        rst;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic [15:0] DataOut;
   logic        Done;
   logic        Stall;
   logic        err;

   int total = 0;
   int bad   = 0;

   mem_responder #(.LATENCY(L), .AW(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .Addr    (Addr),
      .DataIn  (DataIn),
      .Rd      (Rd),
      .Wr      (Wr),
      .DataOut (DataOut),
      .Done    (Done),
      .Stall   (Stall),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: one outstanding transaction described by its accept cycle.
   int          cyc = 0;
   int          acc = 0;
   int          free_at = 0;
   bit          pend = 0;
   bit          model_ok = 0;
   logic [15:0] m_addr, m_dat;
   logic        m_rd, m_wr;
   logic [15:0] exp_dout = 16'h0000;
   logic [15:0] mem_m [256];

   function automatic int widx(input logic [15:0] a);
      return (int'(a) % 512) / 2;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         pend     = 0;
         exp_dout = 16'h0000;
         free_at  = cyc + 1;
         model_ok = 1;
      end else begin
         if (pend && cyc == acc + L - 1) begin
            if ((m_rd && m_wr) || m_addr[0])
               exp_dout = 16'h0000;
            else if (m_wr)
               mem_m[widx(m_addr)] = m_dat;
            else
               exp_dout = mem_m[widx(m_addr)];
         end
         if (pend && cyc == acc + L)
            pend = 0;
         if (!pend && cyc >= free_at && (Rd || Wr)) begin
            pend    = 1;
            acc     = cyc;
            free_at = cyc + L + 1;
            m_addr  = Addr;
            m_dat   = DataIn;
            m_rd    = Rd;
            m_wr    = Wr;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         logic e_stall, e_done;
         e_stall = pend && (cyc > acc) && (cyc < acc + L);
         e_done  = pend && (cyc == acc + L);
         chk("stall", Stall, e_stall);
         chk("done", Done, e_done);
         chk("err", err, e_done && ((m_rd && m_wr) || m_addr[0]));
         chk("dataout", DataOut, exp_dout);
      end
   end

   // Issue one request from just after a rising edge; returns at the same phase.
   task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                      input bit intrude, output logic [15:0] dout, output logic er, output int lat);
      bit seen;
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      @(posedge clk); #1;
      if (intrude) begin
         Rd = 1'b0; Wr = 1'b1; Addr = a + 16'h0042; DataIn = 16'hDEAD;
      end else begin
         Rd = 1'b0; Wr = 1'b0;
      end
      seen = 0; lat = 0; dout = 16'h0000; er = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (Done) begin
            seen = 1;
            dout = DataOut;
            er   = err;
         end
      end
      Rd = 1'b0; Wr = 1'b0;
      if (!seen) chk("done_timeout", 32'(seen), 32'd1);
      @(posedge clk); #1;
   endtask

   logic [15:0] d;
   logic        e;
   int          lat;

   initial begin
      rst = 1'b0; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0004; DataIn = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", Stall, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_dataout", DataOut, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b1; Rd = 1'b0;
      @(negedge clk);
      chk("no_accept_in_reset", Stall, 1'b0);
      @(posedge clk); #1;

      for (int i = 0; i < 256; i++)
         txn(1'b0, 1'b1, 16'(i * 2), 16'($urandom), 0, d, e, lat);

      txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, d, e, lat);
      chk("wr_latency", lat, 32'd4);
      chk("wr_err", e, 1'b0);
      txn(1'b1, 1'b0, 16'h0010, 16'h0000, 0, d, e, lat);
      chk("rd_latency", lat, 32'd4);
      chk("raw_data", d, 16'hBEEF);
      chk("rd_err", e, 1'b0);

      txn(1'b1, 1'b0, 16'h0003, 16'h0000, 0, d, e, lat);
      chk("unaligned_latency", lat, 32'd4);
      chk("unaligned_err", e, 1'b1);
      chk("unaligned_data", d, 16'h0000);

      txn(1'b0, 1'b1, 16'h0020, 16'h5555, 0, d, e, lat);
      txn(1'b1, 1'b1, 16'h0020, 16'h1234, 0, d, e, lat);
      chk("rdwr_err", e, 1'b1);
      txn(1'b1, 1'b0, 16'h0020, 16'h0000, 0, d, e, lat);
      chk("rdwr_no_commit", d, 16'h5555);

      txn(1'b0, 1'b1, 16'h0202, 16'hA5A5, 0, d, e, lat);
      txn(1'b1, 1'b0, 16'h0002, 16'h0000, 0, d, e, lat);
      chk("wrap_data", d, 16'hA5A5);

      txn(1'b0, 1'b1, 16'h0040, 16'h7777, 0, d, e, lat);
      Wr = 1'b1; Addr = 16'h0040; DataIn = 16'h9999;
      @(posedge clk); #1;
      Wr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_stall", Stall, 1'b0);
      chk("abort_done", Done, 1'b0);
      chk("abort_dataout", DataOut, 16'h0000);
      @(posedge clk); #1;
      txn(1'b1, 1'b0, 16'h0040, 16'h0000, 0, d, e, lat);
      chk("abort_no_commit", d, 16'h7777);

      txn(1'b0, 1'b1, 16'h0052, 16'h3C3C, 0, d, e, lat);
      txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1, d, e, lat);
      chk("intrude_latency", lat, 32'd4);
      chk("intrude_data", d, 16'hBEEF);
      txn(1'b1, 1'b0, 16'h0052, 16'h0000, 0, d, e, lat);
      chk("intrude_ignored", d, 16'h3C3C);

      for (int n = 0; n < 300; n++) begin
         int          kind;
         logic [15:0] a;
         kind = int'($urandom_range(0, 9));
         a    = 16'($urandom);
         if (kind != 0) a[0] = 1'b0;
         if (kind == 1)
            txn(1'b1, 1'b1, a, 16'($urandom), 0, d, e, lat);
         else
            txn(kind[0], ~kind[0], a, 16'($urandom), ($urandom_range(0, 3) == 0), d, e, lat);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request sample to Done (legal range 2..15).
REQ-002 SHALL have parameter AW, default 8, log2 of word depth (256 x 16-bit words).
REQ-003 SHALL have a single clock `clk`; reset `rst` is synchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 Addr  in  16  byte address from initiator.
REQ-007 DataIn  in  16  write data.
REQ-008 Rd  in  1  read request.
REQ-009 Wr  in  1  write request.
REQ-010 DataOut  out  16  read data, valid only when Done=1.
REQ-011 Done  out  1  one-cycle completion pulse.
REQ-012 Stall  out  1  responder busy; initiator holds Addr/DataIn/Rd/Wr stable.
REQ-013 err  out  1  illegal request flag, valid with Done.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-015 IDLE: on rising edge with Rd|Wr=1, capture Addr, DataIn, Rd, Wr; load cycle counter with LATENCY-2; go BUSY.
REQ-016 IDLE with Rd=Wr=0: remain IDLE; Stall=0, Done=0.
REQ-017 BUSY: Stall=1; counter decrements each cycle; at counter=0 go RESP.
REQ-018 Timing: request sampled at edge ending cycle N -> Done=1 during cycle N+LATENCY, Stall=1 during cycles N+1..N+LATENCY-1.
REQ-019 RESP: Done=1, Stall=0 for exactly one cycle; then IDLE unconditionally.
REQ-020 Requests presented during BUSY or RESP SHALL be ignored; next accept is no earlier than the first IDLE cycle after RESP.
REQ-021 Write SHALL commit to array on the BUSY->RESP edge; read data SHALL be latched to DataOut on that edge.
REQ-022 Word index = captured Addr[AW:1]; Addr[15:AW+1] ignored (address wraps modulo 2^(AW+1) bytes).
REQ-023 Illegal request: Rd&Wr both 1, or Addr[0]=1 (unaligned).
REQ-024 Illegal request SHALL follow normal latency; no write committed; DataOut=0; err=1 with Done.
REQ-025 err SHALL be 0 whenever Done=0.
REQ-026 DataOut SHALL hold its last value outside RESP, except at reset.
REQ-027 Read-after-write to the same address on consecutive transactions SHALL return the newly written data.

Reset
REQ-028 On rst=0 at a clock edge: state IDLE, counter 0, Done=0, Stall=0, err=0, DataOut=16'h0000.
REQ-029 Reset mid-BUSY SHALL abandon the transaction; the pending write SHALL NOT be committed.
REQ-030 Memory array contents SHALL NOT be cleared by reset.
REQ-031 A request present during the reset cycle SHALL NOT be accepted; first accept is on the first edge with rst=1.

Structure
REQ-032 Shared package mem_pkg SHALL hold FSM state encoding, default LATENCY and AW constants.
REQ-033 Array SHALL be a sub-module mem_array_sync: 2^AW x 16, one synchronous write port, one read port.
REQ-034 Counter width SHALL be 4 bits.

Verification
REQ-035 Write Addr=16'h0010, DataIn=16'hBEEF at cycle 0; then read 16'h0010 -> Done at cycle 4 for both, DataOut=16'hBEEF, err=0.
REQ-036 Read with Addr=16'h0003 -> Done at cycle LATENCY, err=1, DataOut=16'h0000, no array change.
REQ-037 Rd=Wr=1, Addr=16'h0020, DataIn=16'h1234 -> err=1; subsequent read of 16'h0020 returns prior contents.
REQ-038 Write 16'hA5A5 to 16'h0202 (AW=8) then read 16'h0002 -> DataOut=16'hA5A5 (wrap).
REQ-039 Write issued, rst=0 asserted in second BUSY cycle -> all outputs reset next cycle; later read of that address returns old data.
REQ-040 New request driven during BUSY with different Addr -> ignored; Stall stays 1; only original transaction completes.
